ps2_frame_receiver: RTL



---
 rtl/ps2_frame_receiver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialisation,
// and folding of 0xE0/0xF0 prefixes into flags on a single scancode event.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_error,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    dat_sync_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_clk_reg;
  logic          filt_clk_prev_reg;
  logic          clk_s;
  logic          dat_s;
  logic          strobe;

  state_t        state_reg;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt_reg;
  logic          ok_par_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          ext_pending_reg;
  logic          brk_pending_reg;

  assign clk_s  = clk_sync_reg[1];
  assign dat_s  = dat_sync_reg[1];
  assign strobe = filt_clk_prev_reg & ~filt_clk_reg;

  // Synchronisers idle high so reset does not fake a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], ps2_clock};
      dat_sync_reg <= {dat_sync_reg[0], ps2_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_cnt_reg      <= '0;
      filt_clk_reg      <= 1'b1;
      filt_clk_prev_reg <= 1'b1;
    end else begin
      filt_clk_prev_reg <= filt_clk_reg;
      if (clk_s == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_clk_reg <= clk_s;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      ok_par_reg      <= 1'b0;
      to_cnt_reg      <= '0;
      ext_pending_reg <= 1'b0;
      brk_pending_reg <= 1'b0;
      code_valid      <= 1'b0;
      code            <= '0;
      is_break        <= 1'b0;
      is_extended     <= 1'b0;
      frame_error     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (state_reg == IDLE || strobe)
        to_cnt_reg <= '0;
      else
        to_cnt_reg <= to_cnt_reg + 1'b1;

      // A strobe in the same cycle as the timeout wins.
      if (strobe) begin
        case (state_reg)
          IDLE: begin
            if (!dat_s) begin
              shift_reg   <= '0;
              bit_cnt_reg <= '0;
              state_reg   <= DATA;
              busy        <= 1'b1;
            end
          end
          DATA: begin
            shift_reg   <= {dat_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7)
              state_reg <= PARITY;
          end
          PARITY: begin
            ok_par_reg <= ^{shift_reg, dat_s};
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            if (dat_s && ok_par_reg) begin
              if (shift_reg == 8'hE0) begin
                ext_pending_reg <= 1'b1;
              end else if (shift_reg == 8'hF0) begin
                brk_pending_reg <= 1'b1;
              end else begin
                code_valid      <= 1'b1;
                code            <= shift_reg;
                is_break        <= brk_pending_reg;
                is_extended     <= ext_pending_reg;
                ext_pending_reg <= 1'b0;
                brk_pending_reg <= 1'b0;
              end
            end else begin
              frame_error     <= 1'b1;
              ext_pending_reg <= 1'b0;
              brk_pending_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end else if (state_reg != IDLE && to_cnt_reg == TW'(TIMEOUT_CYCLES)) begin
        state_reg       <= IDLE;
        busy            <= 1'b0;
        frame_error     <= 1'b1;
        ext_pending_reg <= 1'b0;
        brk_pending_reg <= 1'b0;
      end
    end
  end

endmodule
